// File: rtl/osu_pkg.sv
// Shared grade/state types, per-grade score constants and default timing windows
// for the hit-object judgement datapath.
package osu_pkg;

    typedef enum logic [1:0] {
        GRADE_MISS = 2'd0,
        GRADE_50   = 2'd1,
        GRADE_100  = 2'd2,
        GRADE_300  = 2'd3
    } grade_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACTIVE,
        ST_REPORT
    } judge_state_e;

    localparam int DEF_HIT_RADIUS = 32;
    localparam int DEF_WIN_300    = 3;
    localparam int DEF_WIN_100    = 6;
    localparam int DEF_WIN_50     = 9;

    localparam logic [23:0] SCORE_50  = 24'd50;
    localparam logic [23:0] SCORE_100 = 24'd100;
    localparam logic [23:0] SCORE_300 = 24'd300;

    function automatic logic [23:0] grade_points(input grade_e g);
        case (g)
            GRADE_300: return SCORE_300;
            GRADE_100: return SCORE_100;
            GRADE_50:  return SCORE_50;
            default:   return 24'd0;
        endcase
    endfunction

endpackage

// File: rtl/hit_distance.sv
// Registered circle test: squares the cursor-to-centre offsets on a click and
// compares their sum against the radius squared one cycle later.
module hit_distance
    import osu_pkg::*;
#(
    parameter int HIT_RADIUS = DEF_HIT_RADIUS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vld_p0,
    input  logic [9:0] cursor_x,
    input  logic [9:0] cursor_y,
    input  logic [9:0] centre_x,
    input  logic [9:0] centre_y,
    output logic       vld_p1,
    output logic       in_p1
);
    localparam logic [21:0] R_SQ = 22'(HIT_RADIUS * HIT_RADIUS);

    logic signed [10:0] dx_p0, dy_p0;
    logic signed [21:0] sq_x_p1, sq_y_p1;
    logic        [21:0] dist_p1;

    assign dx_p0 = signed'({1'b0, cursor_x}) - signed'({1'b0, centre_x});
    assign dy_p0 = signed'({1'b0, cursor_y}) - signed'({1'b0, centre_y});

    // Stage p0 -> p1: squared offsets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            sq_x_p1 <= 22'(dx_p0) * 22'(dx_p0);
            sq_y_p1 <= 22'(dy_p0) * 22'(dy_p0);
        end
    end

    assign dist_p1 = $unsigned(sq_x_p1) + $unsigned(sq_y_p1);
    assign in_p1   = (dist_p1 <= R_SQ);

endmodule

// File: rtl/hit_judge.sv
// Hit-object judgement: grades a mouse click against a frame-stamped circle.
// Define HIT_JUDGE_SCORE_EN to build the combo/score accumulators; otherwise both read zero.
module hit_judge
    import osu_pkg::*;
#(
    parameter int HIT_RADIUS = DEF_HIT_RADIUS,
    parameter int WIN_300    = DEF_WIN_300,
    parameter int WIN_100    = DEF_WIN_100,
    parameter int WIN_50     = DEF_WIN_50
) (
    input  logic        Clk,
    input  logic        reset_rtl_0,
    input  logic        vsync,
    input  logic [9:0]  CursorX,
    input  logic [9:0]  CursorY,
    input  logic        button_clicked,
    input  logic        obj_valid,
    output logic        obj_ready,
    input  logic [9:0]  obj_x,
    input  logic [9:0]  obj_y,
    input  logic [15:0] obj_time,
    output logic [15:0] frame_count,
    output logic        judge_valid,
    output logic [1:0]  judge_grade,
    output logic [9:0]  combo,
    output logic [23:0] score
);
    localparam logic        [15:0] W300 = 16'(WIN_300);
    localparam logic        [15:0] W100 = 16'(WIN_100);
    localparam logic signed [15:0] W50  = 16'(WIN_50);

    judge_state_e       state, next_state;
    logic               vsync_s1, vsync_s2, vsync_d;
    logic               btn_s1, btn_s2, btn_d;
    logic               frame_tick, click_rise;
    logic        [15:0] frame_cnt;
    logic        [9:0]  obj_x_q, obj_y_q;
    logic        [15:0] obj_time_q;
    logic signed [15:0] frame_err_p0, frame_err_p1;
    logic        [15:0] abs_err_p1;
    logic               vld_p0, vld_p1, in_p1;
    logic               load_grade;
    grade_e             grade_next, grade_q;

    function automatic grade_e grade_of(input logic [15:0] abs_err);
        if (abs_err <= W300)      return GRADE_300;
        else if (abs_err <= W100) return GRADE_100;
        else                      return GRADE_50;
    endfunction

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            {vsync_s1, vsync_s2, vsync_d} <= 3'b000;
            {btn_s1, btn_s2, btn_d}       <= 3'b000;
            frame_cnt                     <= 16'd0;
        end else begin
            {vsync_s1, vsync_s2, vsync_d} <= {vsync, vsync_s1, vsync_s2};
            {btn_s1, btn_s2, btn_d}       <= {button_clicked, btn_s1, btn_s2};
            if (frame_tick) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign frame_tick  = vsync_s2 & ~vsync_d;
    assign click_rise  = btn_s2 & ~btn_d;
    assign frame_count = frame_cnt;

    // The descriptor is plain data; only the FSM state decides whether it is live.
    always_ff @(posedge Clk) begin
        if (state == ST_IDLE && obj_valid) begin
            obj_x_q    <= obj_x;
            obj_y_q    <= obj_y;
            obj_time_q <= obj_time;
        end
    end

    // Modular difference keeps the window compares correct across the frame wrap.
    assign frame_err_p0 = signed'(frame_cnt - obj_time_q);
    assign vld_p0       = click_rise && (state == ST_ACTIVE);

    // Stage p0 -> p1: frame error frozen at the click, before any same-cycle frame tick
    always_ff @(posedge Clk) begin
        if (vld_p0) frame_err_p1 <= frame_err_p0;
    end

    assign abs_err_p1 = frame_err_p1[15] ? $unsigned(-frame_err_p1) : $unsigned(frame_err_p1);

    hit_distance #(.HIT_RADIUS(HIT_RADIUS)) u_dist (
        .clk      (Clk),
        .rst_n    (reset_rtl_0),
        .vld_p0   (vld_p0),
        .cursor_x (CursorX),
        .cursor_y (CursorY),
        .centre_x (obj_x_q),
        .centre_y (obj_y_q),
        .vld_p1   (vld_p1),
        .in_p1    (in_p1)
    );

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            state   <= ST_IDLE;
            grade_q <= GRADE_MISS;
        end else begin
            state <= next_state;
            if (load_grade) grade_q <= grade_next;
        end
    end

    always_comb begin
        next_state = state;
        grade_next = GRADE_MISS;
        load_grade = 1'b0;
        case (state)
            ST_IDLE:   if (obj_valid) next_state = ST_WAIT;
            ST_WAIT:   if (frame_err_p0 >= -W50) next_state = ST_ACTIVE;
            ST_ACTIVE: begin
                // A click in the distance stage outranks the miss timeout.
                if (vld_p1) begin
                    if (in_p1) begin
                        next_state = ST_REPORT;
                        grade_next = grade_of(abs_err_p1);
                        load_grade = 1'b1;
                    end
                end else if (frame_err_p0 > W50) begin
                    next_state = ST_REPORT;
                    load_grade = 1'b1;
                end
            end
            ST_REPORT: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    assign obj_ready   = (state == ST_IDLE);
    assign judge_valid = (state == ST_REPORT);
    assign judge_grade = grade_q;

`ifdef HIT_JUDGE_SCORE_EN
    function automatic logic [9:0] sat_inc_combo(input logic [9:0] c);
        return (c == 10'h3FF) ? c : c + 10'd1;
    endfunction

    function automatic logic [23:0] sat_add_score(input logic [23:0] s, input logic [23:0] p);
        logic [24:0] sum;
        sum = {1'b0, s} + {1'b0, p};
        return sum[24] ? 24'hFF_FFFF : sum[23:0];
    endfunction

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            combo <= 10'd0;
            score <= 24'd0;
        end else if (load_grade) begin
            combo <= (grade_next == GRADE_MISS) ? 10'd0 : sat_inc_combo(combo);
            score <= sat_add_score(score, grade_points(grade_next));
        end
    end
`else
    assign combo = 10'd0;
    assign score = 24'd0;
`endif

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: a vector table of single-object judgements plus
// hand sequences for frame wrap, coincident tick/click, combo chaining and reset.
module tb_hit_judge;

    logic        Clk = 1'b0;
    logic        reset_rtl_0 = 1'b0;
    logic        vsync = 1'b0;
    logic [9:0]  CursorX = '0, CursorY = '0;
    logic        button_clicked = 1'b0;
    logic        obj_valid = 1'b0;
    logic        obj_ready;
    logic [9:0]  obj_x = '0, obj_y = '0;
    logic [15:0] obj_time = '0;
    logic [15:0] frame_count;
    logic        judge_valid;
    logic [1:0]  judge_grade;
    logic [9:0]  combo;
    logic [23:0] score;

    int checks = 0;
    int errors = 0;

    int jv_count = 0;
    int jv_frame, jv_grade, jv_combo, jv_score;

    hit_judge dut (
        .Clk            (Clk),
        .reset_rtl_0    (reset_rtl_0),
        .vsync          (vsync),
        .CursorX        (CursorX),
        .CursorY        (CursorY),
        .button_clicked (button_clicked),
        .obj_valid      (obj_valid),
        .obj_ready      (obj_ready),
        .obj_x          (obj_x),
        .obj_y          (obj_y),
        .obj_time       (obj_time),
        .frame_count    (frame_count),
        .judge_valid    (judge_valid),
        .judge_grade    (judge_grade),
        .combo          (combo),
        .score          (score)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (judge_valid) begin
            jv_count = jv_count + 1;
            jv_frame = int'(frame_count);
            jv_grade = int'(judge_grade);
            jv_combo = int'(combo);
            jv_score = int'(score);
        end
    end

    typedef struct {
        logic [9:0] cx;
        logic [9:0] cy;
        int         cf;
        bit         hit;
        int         grade;
        int         pts;
    } vec_t;

    vec_t vecs[14];

    function automatic int exp_score(input int pts);
`ifdef HIT_JUDGE_SCORE_EN
        return pts;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_combo(input int c);
`ifdef HIT_JUDGE_SCORE_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_rtl_0    = 1'b0;
        vsync          = 1'b0;
        button_clicked = 1'b0;
        obj_valid      = 1'b0;
        repeat (2) @(negedge Clk);
        reset_rtl_0 = 1'b1;
        @(negedge Clk);
    endtask

    task automatic tick_frame();
        vsync = 1'b1;
        repeat (2) @(negedge Clk);
        vsync = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic tick_to(input int f);
        for (int i = 0; i < 200 && int'(frame_count) != f; i++) tick_frame();
    endtask

    task automatic load_obj(input logic [9:0] x, input logic [9:0] y, input logic [15:0] t);
        check("obj_ready_idle", int'(obj_ready), 1);
        obj_x = x; obj_y = y; obj_time = t; obj_valid = 1'b1;
        @(negedge Clk);
        obj_valid = 1'b0;
        @(negedge Clk);
        check("obj_ready_busy", int'(obj_ready), 0);
    endtask

    task automatic click(input logic [9:0] x, input logic [9:0] y, output int lat);
        lat = 0;
        CursorX = x; CursorY = y; button_clicked = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clk);
            if (judge_valid && lat == 0) lat = i;
        end
        button_clicked = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic wait_pulse(input int n0, input int max_frames, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_frames && !seen; i++) begin
            tick_frame();
            if (jv_count != n0) seen = 1'b1;
        end
    endtask

    int  lat, n0;
    bit  seen;

    initial begin
        vecs[0]  = '{10'd330, 10'd245, 101, 1'b1, 3, 300};
        vecs[1]  = '{10'd320, 10'd240, 106, 1'b1, 2, 100};
        vecs[2]  = '{10'd400, 10'd240, 100, 1'b0, 0, 0};
        vecs[3]  = '{10'd320, 10'd240, 109, 1'b1, 1, 50};
        vecs[4]  = '{10'd320, 10'd240,  91, 1'b1, 1, 50};
        vecs[5]  = '{10'd320, 10'd240,  97, 1'b1, 3, 300};
        vecs[6]  = '{10'd320, 10'd240,  94, 1'b1, 2, 100};
        vecs[7]  = '{10'd352, 10'd240, 100, 1'b1, 3, 300};
        vecs[8]  = '{10'd353, 10'd240, 100, 1'b0, 0, 0};
        vecs[9]  = '{10'd342, 10'd262, 103, 1'b1, 3, 300};
        vecs[10] = '{10'd343, 10'd263, 100, 1'b0, 0, 0};
        vecs[11] = '{10'd300, 10'd220, 104, 1'b1, 2, 100};
        vecs[12] = '{10'd320, 10'd240,  90, 1'b0, 0, 0};
        vecs[13] = '{10'd320, 10'd208, 107, 1'b1, 1, 50};

        repeat (2) @(negedge Clk);
        check("rst_frame", int'(frame_count), 0);
        check("rst_valid", int'(judge_valid), 0);
        check("rst_grade", int'(judge_grade), 0);
        check("rst_combo", int'(combo), 0);
        check("rst_score", int'(score), 0);
        reset_rtl_0 = 1'b1;
        @(negedge Clk);
        check("rst_ready", int'(obj_ready), 1);

        // Table: one object (320,240,t=100) per vector, from a fresh reset
        foreach (vecs[v]) begin
            do_reset();
            load_obj(10'd320, 10'd240, 16'd100);
            tick_to(vecs[v].cf);
            click(vecs[v].cx, vecs[v].cy, lat);
            if (vecs[v].hit) begin
                check($sformatf("v%0d_latency", v), lat, 4);
                check($sformatf("v%0d_grade", v), jv_grade, vecs[v].grade);
                check($sformatf("v%0d_combo", v), jv_combo, exp_combo(1));
                check($sformatf("v%0d_score", v), jv_score, exp_score(vecs[v].pts));
                repeat (3) @(negedge Clk);
                check($sformatf("v%0d_grade_hold", v), int'(judge_grade), vecs[v].grade);
                check($sformatf("v%0d_valid_low", v), int'(judge_valid), 0);
            end else begin
                check($sformatf("v%0d_no_hit", v), lat, 0);
                n0 = jv_count;
                wait_pulse(n0, 30, seen);
                check($sformatf("v%0d_miss_seen", v), int'(seen), 1);
                check($sformatf("v%0d_miss_frame", v), jv_frame, 110);
                check($sformatf("v%0d_miss_grade", v), jv_grade, 0);
                check($sformatf("v%0d_miss_combo", v), jv_combo, 0);
            end
        end

        // Frame counter wrap: obj_time 3, counter preset to 65533, click on frame 1
        do_reset();
        load_obj(10'd320, 10'd240, 16'd3);
        force dut.frame_cnt = 16'd65533;
        @(negedge Clk);
        release dut.frame_cnt;
        @(negedge Clk);
        repeat (4) tick_frame();
        check("wrap_frame", int'(frame_count), 1);
        click(10'd320, 10'd240, lat);
        check("wrap_latency", lat, 4);
        check("wrap_grade", jv_grade, 3);

        // Frame tick and click land together on frame 109: judged at d=9, not a miss
        do_reset();
        load_obj(10'd320, 10'd240, 16'd100);
        tick_to(109);
        lat = 0;
        CursorX = 10'd320; CursorY = 10'd240;
        vsync = 1'b1; button_clicked = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clk);
            if (i == 2) vsync = 1'b0;
            if (judge_valid && lat == 0) lat = i;
        end
        button_clicked = 1'b0;
        repeat (3) @(negedge Clk);
        check("coinc_latency", lat, 4);
        check("coinc_grade", jv_grade, 1);
        check("coinc_frame", jv_frame, 110);

        // Chain: miss, 300, 100 without reset between objects
        do_reset();
        load_obj(10'd320, 10'd240, 16'd100);
        n0 = jv_count;
        wait_pulse(n0, 120, seen);
        check("chain_miss_seen", int'(seen), 1);
        check("chain_miss_frame", jv_frame, 110);
        check("chain_miss_combo", jv_combo, 0);
        @(negedge Clk);
        load_obj(10'd320, 10'd240, 16'd120);
        tick_to(121);
        click(10'd330, 10'd245, lat);
        check("chain_a_grade", jv_grade, 3);
        check("chain_a_combo", jv_combo, exp_combo(1));
        check("chain_a_score", jv_score, exp_score(300));
        load_obj(10'd320, 10'd240, 16'd130);
        tick_to(136);
        click(10'd320, 10'd240, lat);
        check("chain_b_grade", jv_grade, 2);
        check("chain_b_combo", jv_combo, exp_combo(2));
        check("chain_b_score", jv_score, exp_score(400));

        // Reset one cycle after a click edge, mid-judgement
        load_obj(10'd320, 10'd240, 16'd150);
        tick_to(151);
        n0 = jv_count;
        CursorX = 10'd330; CursorY = 10'd245; button_clicked = 1'b1;
        repeat (3) @(negedge Clk);
        reset_rtl_0 = 1'b0;
        #1;
        check("mid_rst_valid", int'(judge_valid), 0);
        check("mid_rst_grade", int'(judge_grade), 0);
        check("mid_rst_frame", int'(frame_count), 0);
        check("mid_rst_combo", int'(combo), 0);
        check("mid_rst_score", int'(score), 0);
        repeat (3) @(negedge Clk);
        button_clicked = 1'b0;
        reset_rtl_0 = 1'b1;
        @(negedge Clk);
        check("mid_rst_ready", int'(obj_ready), 1);
        repeat (6) @(negedge Clk);
        check("mid_rst_no_pulse", jv_count, n0);
        repeat (15) tick_frame();
        check("discarded_obj_no_pulse", jv_count, n0);
        check("discarded_obj_ready", int'(obj_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
